ca_correlator_acc: RTL and testbench
====================================

// Module: ca_correlator_acc
// PURPOSE
//  Per-channel correlator accumulator: consumer of the early/prompt/late chips and dump_enable from the
//  C/A code generator. Wipes the code off carrier-mixed I/Q samples, integrates per code replica,
//  and at each dump_enable latches six sums plus sample count for the processor, with a
//  new-data flag, read acknowledge and sticky overrun.
// PARAMETERS
//  IN_W   3   signed width of i_in/q_in (carrier-mixed baseband)
//  ACC_W  16  signed width of accumulators and dump registers
//  CNT_W  16  width of per-dump sample counter
// PORTS
//  clk          in   1      system clock
//  rstn         in   1      async reset, active low
//  clear        in   1      sync clear (channel re-init, same pulse as prn_key_enable)
//  sample_en    in   1      one baseband sample valid this cycle
//  i_in, q_in   in   IN_W   signed I/Q samples, qualified by sample_en
//  early        in   1      early chip
//  prompt       in   1      prompt chip
//  late         in   1      late chip
//  dump_enable  in   1      single-cycle end-of-code-period pulse
//  acc_ack      in   1      processor read done; clears acc_valid and overrun
//  i_e,q_e,i_p,q_p,i_l,q_l out ACC_W  latched dump sums (signed)
//  samp_cnt     out  CNT_W  samples integrated in latched period
//  acc_valid    out  1      new dump data available
//  overrun      out  1      sticky: dump occurred while acc_valid set and not acked
// BEHAVIOUR
//  - Reset (rstn=0, async): all accumulators, dump regs, samp_cnt, acc_valid, overrun = 0.
//  - clear (sync, highest priority after reset): same zeroing as reset; overrides dump/ack that cycle.
//  - Code wipe-off: chip 0 -> +sample, chip 1 -> -sample; sign-extend IN_W to ACC_W before add.
//  - On sample_en: each of 6 accumulators adds its wiped sample; running count += 1.
//  - Saturation: sums clamp at +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)); no wrap. Count saturates at all-ones.
//  - dump_enable: dump regs <= accumulator value INCLUDING any sample_en in the same cycle;
//    samp_cnt likewise; accumulators and count restart at 0 next cycle. 1-cycle latency to outputs.
//  - acc_valid: set on dump; cleared on acc_ack. dump && acc_ack same cycle -> acc_valid stays 1,
//    overrun not set (ack applies to old data).
//  - overrun: set on dump while acc_valid=1 and acc_ack=0; dump regs still overwritten with new data;
//    cleared only by acc_ack or clear.
//  - acc_ack with acc_valid=0: no effect.
//  - Back-to-back dumps with no samples: dump regs = 0, samp_cnt = 0.
//  - Outputs stable between dumps; no combinational path input->output.
// TESTING
//  1. rstn low mid-integration -> all outputs 0 immediately (async), integration restarts cleanly.
//  2. i_in=+3,q_in=-2, early=0,prompt=1,late=0, 10 samples, dump -> i_e=30,q_e=-20,i_p=-30,
//     q_p=20,i_l=30,q_l=-20, samp_cnt=10, acc_valid=1 next cycle.
//  3. Sample i_in=+1 coincident with dump after 4 samples of +1 (chips 0) -> i_e=5, next period starts at 0.
//  4. Two dumps without acc_ack -> overrun=1, regs hold second sum; acc_ack -> acc_valid=0, overrun=0.
//  5. dump and acc_ack same cycle with acc_valid=1 -> acc_valid=1, overrun=0.
//  6. ACC_W=8, 50 samples of +3 chip 0 -> i_e=127 (saturated); clear mid-period -> all zero, acc_valid=0.

Source files
------------

// File: rtl/ca_correlator_acc.sv
// Per-channel early/prompt/late correlator: wipes the C/A chip off I/Q samples, integrates
// with saturation, and latches six sums plus a sample count on each dump for the processor.
module ca_correlator_acc #(
    parameter int IN_W  = 3,
    parameter int ACC_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    sample_en,
    input  logic signed [IN_W-1:0]  i_in,
    input  logic signed [IN_W-1:0]  q_in,
    input  logic                    early,
    input  logic                    prompt,
    input  logic                    late,
    input  logic                    dump_enable,
    input  logic                    acc_ack,
    output logic signed [ACC_W-1:0] i_e,
    output logic signed [ACC_W-1:0] q_e,
    output logic signed [ACC_W-1:0] i_p,
    output logic signed [ACC_W-1:0] q_p,
    output logic signed [ACC_W-1:0] i_l,
    output logic signed [ACC_W-1:0] q_l,
    output logic [CNT_W-1:0]        samp_cnt,
    output logic                    acc_valid,
    output logic                    overrun
);

    // Index order of every six-entry array: i_e, q_e, i_p, q_p, i_l, q_l
    logic signed [ACC_W-1:0] acc_q  [6];
    logic signed [ACC_W-1:0] acc_d  [6];
    logic signed [ACC_W-1:0] dump_q [6];
    logic signed [ACC_W-1:0] dump_d [6];
    logic signed [ACC_W-1:0] wipe   [6];
    logic signed [ACC_W-1:0] sum    [6];
    logic signed [ACC_W-1:0] i_ext, q_ext;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_sum;
    logic [CNT_W-1:0]        samp_q, samp_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    always_comb begin
        i_ext = {{(ACC_W-IN_W){i_in[IN_W-1]}}, i_in};
        q_ext = {{(ACC_W-IN_W){q_in[IN_W-1]}}, q_in};
        // chip 1 inverts the sample, chip 0 passes it
        wipe[0] = early  ? -i_ext : i_ext;
        wipe[1] = early  ? -q_ext : q_ext;
        wipe[2] = prompt ? -i_ext : i_ext;
        wipe[3] = prompt ? -q_ext : q_ext;
        wipe[4] = late   ? -i_ext : i_ext;
        wipe[5] = late   ? -q_ext : q_ext;
        for (int k = 0; k < 6; k++)
            sum[k] = sample_en ? sat_add(acc_q[k], wipe[k]) : acc_q[k];
        cnt_sum = (sample_en && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        acc_d   = sum;
        dump_d  = dump_q;
        cnt_d   = cnt_sum;
        samp_d  = samp_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clear) begin
            for (int k = 0; k < 6; k++) begin
                acc_d[k]  = '0;
                dump_d[k] = '0;
            end
            cnt_d   = '0;
            samp_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (dump_enable) begin
                dump_d = sum;
                samp_d = cnt_sum;
                for (int k = 0; k < 6; k++)
                    acc_d[k] = '0;
                cnt_d = '0;
            end
            // an ack in the dump cycle acknowledges the data being replaced, so no overrun
            if (dump_enable)
                valid_d = 1'b1;
            else if (acc_ack)
                valid_d = 1'b0;
            if (acc_ack)
                ovr_d = 1'b0;
            else if (dump_enable && valid_q)
                ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 6; k++) begin
                acc_q[k]  <= '0;
                dump_q[k] <= '0;
            end
            cnt_q   <= '0;
            samp_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            dump_q  <= dump_d;
            cnt_q   <= cnt_d;
            samp_q  <= samp_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign i_e       = dump_q[0];
    assign q_e       = dump_q[1];
    assign i_p       = dump_q[2];
    assign q_p       = dump_q[3];
    assign i_l       = dump_q[4];
    assign q_l       = dump_q[5];
    assign samp_cnt  = samp_q;
    assign acc_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_ca_correlator_acc.sv
// Scoreboard bench: two correlators (16-bit and 8-bit/4-bit-count) share stimulus; a reference
// model predicts the registered outputs each cycle and a monitor compares them.
module tb_ca_correlator_acc;
    localparam int WA = 16, CA = 16, WB = 8, CB = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clear = 1'b0, sample_en = 1'b0;
    logic signed [2:0] i_in = '0, q_in = '0;
    logic early = 1'b0, prompt = 1'b0, late = 1'b0, dump_enable = 1'b0, acc_ack = 1'b0;

    logic signed [WA-1:0] a_ie, a_qe, a_ip, a_qp, a_il, a_ql;
    logic [CA-1:0] a_cnt;
    logic a_val, a_ovr;
    logic signed [WB-1:0] b_ie, b_qe, b_ip, b_qp, b_il, b_ql;
    logic [CB-1:0] b_cnt;
    logic b_val, b_ovr;

    always #5 clk = ~clk;

    ca_correlator_acc #(.IN_W(3), .ACC_W(WA), .CNT_W(CA)) dut_a (
        .clk(clk), .rstn(rstn), .clear(clear), .sample_en(sample_en), .i_in(i_in), .q_in(q_in),
        .early(early), .prompt(prompt), .late(late), .dump_enable(dump_enable), .acc_ack(acc_ack),
        .i_e(a_ie), .q_e(a_qe), .i_p(a_ip), .q_p(a_qp), .i_l(a_il), .q_l(a_ql),
        .samp_cnt(a_cnt), .acc_valid(a_val), .overrun(a_ovr));

    ca_correlator_acc #(.IN_W(3), .ACC_W(WB), .CNT_W(CB)) dut_b (
        .clk(clk), .rstn(rstn), .clear(clear), .sample_en(sample_en), .i_in(i_in), .q_in(q_in),
        .early(early), .prompt(prompt), .late(late), .dump_enable(dump_enable), .acc_ack(acc_ack),
        .i_e(b_ie), .q_e(b_qe), .i_p(b_ip), .q_p(b_qp), .i_l(b_il), .q_l(b_ql),
        .samp_cnt(b_cnt), .acc_valid(b_val), .overrun(b_ovr));

    typedef struct packed {
        logic [5:0][31:0] s;
        logic [31:0]      cnt;
        logic             valid;
        logic             ovr;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t m_out[2];
    int   m_acc[2][6];
    int   m_cnt[2];
    int   checks = 0, passed = 0;

    function automatic exp_t actual(input int d);
        exp_t r;
        if (d == 0) begin
            r.s[0] = 32'(a_ie); r.s[1] = 32'(a_qe); r.s[2] = 32'(a_ip);
            r.s[3] = 32'(a_qp); r.s[4] = 32'(a_il); r.s[5] = 32'(a_ql);
            r.cnt = 32'(a_cnt); r.valid = a_val; r.ovr = a_ovr;
        end else begin
            r.s[0] = 32'(b_ie); r.s[1] = 32'(b_qe); r.s[2] = 32'(b_ip);
            r.s[3] = 32'(b_qp); r.s[4] = 32'(b_il); r.s[5] = 32'(b_ql);
            r.cnt = 32'(b_cnt); r.valid = b_val; r.ovr = b_ovr;
        end
        return r;
    endfunction

    task automatic compare(input int d, input exp_t e, input string nm);
        exp_t a;
        a = actual(d);
        checks++;
        if (a === e) passed++;
        else $display("FAIL %s dut%0d: got sums=%h cnt=%0d valid=%b ovr=%b, want sums=%h cnt=%0d valid=%b ovr=%b",
                      nm, d, a.s, a.cnt, a.valid, a.ovr, e.s, e.cnt, e.valid, e.ovr);
    endtask

    task automatic dcheck(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    function automatic int clamp(input int x, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 6; k++) m_acc[d][k] = 0;
            m_cnt[d] = 0;
            m_out[d] = '0;
        end
    endtask

    // Next registered outputs given the inputs currently applied
    task automatic model_step(input int d, input int w, input int cw);
        int iv, qv, smp;
        bit chip;
        bit was_valid;
        iv = i_in;
        qv = q_in;
        if (clear) begin
            for (int k = 0; k < 6; k++) m_acc[d][k] = 0;
            m_cnt[d] = 0;
            m_out[d] = '0;
            return;
        end
        if (sample_en) begin
            for (int k = 0; k < 6; k++) begin
                smp  = (k % 2 == 0) ? iv : qv;
                chip = (k < 2) ? early : (k < 4) ? prompt : late;
                m_acc[d][k] = clamp(m_acc[d][k] + (chip ? -smp : smp), w);
            end
            if (m_cnt[d] < (1 << cw) - 1) m_cnt[d]++;
        end
        was_valid = m_out[d].valid;
        if (dump_enable) begin
            for (int k = 0; k < 6; k++) begin
                m_out[d].s[k] = m_acc[d][k];
                m_acc[d][k] = 0;
            end
            m_out[d].cnt = m_cnt[d];
            m_cnt[d] = 0;
            m_out[d].valid = 1'b1;
        end else if (acc_ack) begin
            m_out[d].valid = 1'b0;
        end
        if (acc_ack) m_out[d].ovr = 1'b0;
        else if (dump_enable && was_valid) m_out[d].ovr = 1'b1;
    endtask

    task automatic cycle(input bit se, input int iv, input int qv, input bit e, input bit p,
                         input bit l, input bit dmp, input bit ack, input bit clr);
        sample_en = se; i_in = 3'(iv); q_in = 3'(qv);
        early = e; prompt = p; late = l;
        dump_enable = dmp; acc_ack = ack; clear = clr;
        model_step(0, WA, CA);
        model_step(1, WB, CB);
        qa.push_back(m_out[0]);
        qb.push_back(m_out[1]);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic async_reset();
        sample_en = 0; dump_enable = 0; acc_ack = 0; clear = 0;
        #2 rstn = 1'b0;
        #1;
        compare(0, '0, "async_reset");
        compare(1, '0, "async_reset");
        model_reset();
        qa.push_back(m_out[0]);
        qb.push_back(m_out[1]);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        while (qa.size() > 0 && qb.size() > 0) begin
            compare(0, qa.pop_front(), "cycle");
            compare(1, qb.pop_front(), "cycle");
        end
    end

    initial begin
        bit fixed;
        int fi;
        bit fe, fp, fl;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare(0, '0, "reset_state");
        compare(1, '0, "reset_state");
        rstn = 1'b1;
        idle(2);

        // 10 samples of I=+3, Q=-2 on prompt chip 1
        for (int i = 0; i < 10; i++) cycle(1, 3, -2, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 1, 0, 0);
        dcheck("t2_i_e", a_ie, 30);   dcheck("t2_q_e", a_qe, -20);
        dcheck("t2_i_p", a_ip, -30);  dcheck("t2_q_p", a_qp, 20);
        dcheck("t2_i_l", a_il, 30);   dcheck("t2_q_l", a_ql, -20);
        dcheck("t2_cnt", a_cnt, 10);  dcheck("t2_valid", a_val, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // sample coincident with dump is included; next period starts from zero
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 1, 0, 0);
        dcheck("t3_i_e", a_ie, 5);    dcheck("t3_cnt", a_cnt, 5);
        cycle(1, 1, 0, 0, 0, 0, 1, 1, 0);
        dcheck("t3_restart", a_ie, 1); dcheck("t5_valid", a_val, 1); dcheck("t5_ovr", a_ovr, 0);

        // second dump without ack -> overrun, regs carry new data
        cycle(1, 2, 1, 1, 0, 0, 1, 0, 0);
        dcheck("t4_ovr", a_ovr, 1);   dcheck("t4_i_e", a_ie, -2);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        dcheck("t4_ack_valid", a_val, 0); dcheck("t4_ack_ovr", a_ovr, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // back-to-back dumps with no samples
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        dcheck("b2b_i_e", a_ie, 0);   dcheck("b2b_cnt", a_cnt, 0);

        // saturation of the 8-bit instance, count saturation of the 4-bit counter
        for (int i = 0; i < 50; i++) cycle(1, 3, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        dcheck("t6_sat_b", b_ie, 127); dcheck("t6_a", a_ie, 150);
        dcheck("t6_cnt_b", b_cnt, 15);
        for (int i = 0; i < 5; i++) cycle(1, -4, 3, 1, 0, 1, 0, 0, 0);
        cycle(1, -4, 3, 1, 0, 1, 1, 0, 1);
        dcheck("t6_clear_val", a_val, 0); dcheck("t6_clear_ie", a_ie, 0);

        // mid-integration async reset
        for (int i = 0; i < 7; i++) cycle(1, 2, -3, 1, 1, 0, 0, 0, 0);
        async_reset();
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        dcheck("rst_restart_ie", a_ie, 3);

        // randomized traffic, alternating with held-chip stretches that drive saturation
        fixed = 0; fi = 3; fe = 0; fp = 0; fl = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                fixed = $urandom_range(0, 1);
                fi = $urandom_range(0, 1) ? 3 : -4;
                fe = 1'($urandom); fp = 1'($urandom); fl = 1'($urandom);
            end
            if (n == 1700) async_reset();
            if (fixed)
                cycle($urandom_range(0, 9) < 9, fi, -fi, fe, fp, fl,
                      $urandom_range(0, 99) < 1, $urandom_range(0, 19) == 0,
                      $urandom_range(0, 499) == 0);
            else
                cycle($urandom_range(0, 9) < 7, $urandom_range(0, 7) - 4, $urandom_range(0, 7) - 4,
                      1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 199) == 0);
        end
        idle(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
